cmd_deserializer: RTL and testbench
===================================

Name: cmd_deserializer

Overview:
Parametrised successor to the fixed 7-bit serial-to-parallel wrapper for the SD host CMD path. The block is armed by the command controller and waits for a start bit on the serial CMD line. It then shifts in a full frame, sampling on an external bit-rate strobe, and presents the frame in parallel with a one-cycle push. It also reports end-bit errors and response timeout, and can optionally check the frame's CRC7.

Parameters:
FRAME_W, 48, total frame length in bits, including start and end bits; legal range 9..136.
MSB_FIRST, 1, 1 = first received bit lands at output_n[FRAME_W-1]; 0 = first received bit lands at output_n[0].
START_LVL, 0, serial level that marks the start bit; idle level is its complement.
TIMEOUT_MAX, 64, number of enable strobes allowed in WAIT_START before timeout fires (NCR limit).
TO_W, 7, width of the timeout counter; must satisfy TO_W >= clog2(TIMEOUT_MAX+1).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  bit-rate sample strobe; serial sampled only when high
input_1  in  1  serial CMD line
arm  in  1  1-cycle request to begin listening for a frame
output_n  out  FRAME_W  last received frame, parallel
push  out  1  1-cycle pulse: output_n holds a new frame
frame_err  out  1  1-cycle pulse with push: end bit != ~START_LVL
crc_err  out  1  1-cycle pulse with push: CRC7 mismatch (see Optional Feature)
timeout  out  1  1-cycle pulse: no start bit within TIMEOUT_MAX strobes
busy  out  1  high in WAIT_START and SHIFT

Behaviour:
- Reset values: output_n=0, push=0, frame_err=0, crc_err=0, timeout=0, busy=0, state=IDLE, bit counter=0, timeout counter=0.
- IDLE:
  - arm=1 -> WAIT_START on the next edge; clear the timeout counter.
  - arm is ignored in every other state.
- WAIT_START, on each enable=1 cycle:
  - input_1==START_LVL -> store that bit as frame bit 0, bit counter=1, go to SHIFT.
  - Otherwise increment the timeout counter. When it would reach TIMEOUT_MAX, pulse timeout for 1 cycle and go to IDLE.
- SHIFT:
  - Each enable=1 cycle shifts in input_1 and increments the bit counter.
  - When bit FRAME_W-1 is sampled, the next edge does all of the following:
    - loads the shift register into output_n;
    - pulses push for 1 cycle;
    - pulses frame_err if the last bit != ~START_LVL;
    - pulses crc_err if applicable;
    - returns the state to IDLE.
- Latency: push is asserted the cycle after the edge that samples the final bit.
- enable=0: state, counters and shift register hold.
- output_n is stable between pushes and is never partially updated.
- A new arm in the same cycle as push is ignored, because the FSM is still finishing the frame; the controller re-arms from the next cycle.
- Reset asserted mid-frame: immediate return to reset values on that edge. No push, no error pulse.
- Bit counter width: clog2(FRAME_W+1). No wrap, because the counter stops at FRAME_W-1.
- Busy: busy=1 in WAIT_START and SHIFT, 0 in IDLE (including the push cycle).

Optional Feature:
Macro CMD_DESER_CRC7_EN.
- Defined: a serial CRC7 (polynomial x^7+x^3+1, initial value 0) runs over received bits 0..FRAME_W-9, i.e. everything before the CRC field. The resulting remainder is compared with received bits FRAME_W-8..FRAME_W-2. A mismatch pulses crc_err together with push.
- Not defined: no CRC logic is generated and crc_err is tied to 0. All other behaviour is identical.

Decomposition:
- Package cmd_deser_pkg holds:
  - state enum {IDLE, WAIT_START, SHIFT};
  - CRC7_POLY = 7'h09;
  - CRC7_W = 7;
  - a clog2 helper function.
- One sub-module, crc7_serial: inputs clk, reset, clear, bit_en, bit_in; output crc[6:0]. It is instantiated only under CMD_DESER_CRC7_EN.

Test Plan:
1. Defaults. arm, then input_1 held high for 10 strobes, then serial 48'h400000000095 MSB first with enable every 4th clk -> push once; output_n=48'h400000000095; frame_err=0; crc_err=0 (CRC enabled).
2. Defaults. Same frame with the last bit forced to 0 (48'h400000000094) -> push=1 and frame_err=1 in the same cycle; output_n=48'h400000000094.
3. CRC enabled. Frame 48'h4000000000FF -> push=1, crc_err=1, frame_err=0.
4. Defaults. arm with input_1 held at 1 -> timeout pulses exactly once, after the 64th enable strobe; busy falls with it; push never asserts.
5. Defaults. arm, then reset asserted after 20 frame bits, then a full valid frame -> no push before the reset. After re-arm, push with the correct value; output_n was 0 between the reset and that push.
6. FRAME_W=9, MSB_FIRST=0: bits 0,1,0,1,1,0,0,1,1 -> output_n=9'b110011010; frame_err=0. arm pulsed during SHIFT and in the push cycle is ignored: busy stays 0 after push.

Source files
------------

// File: rtl/cmd_deser_pkg.sv
// cmd_deser_pkg: shared FSM states, CRC7 constants and a clog2 helper for the SD CMD deserializer.
package cmd_deser_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_START, SHIFT} state_e;
    localparam int CRC7_W = 7;
    localparam logic [CRC7_W-1:0] CRC7_POLY = 7'h09;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/crc7_serial.sv
// crc7_serial: bit-serial CRC7 (x^7+x^3+1, init 0), one bit per bit_en, cleared by clear.
import cmd_deser_pkg::*;
module crc7_serial (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              bit_en,
    input  logic              bit_in,
    output logic [CRC7_W-1:0] crc
);
    logic [CRC7_W-1:0] crc_q;
    logic              fb;
    assign fb  = bit_in ^ crc_q[CRC7_W-1];
    assign crc = crc_q;
    always_ff @(posedge clk) begin
        if (reset || clear) crc_q <= '0;
        else if (bit_en) crc_q <= {crc_q[CRC7_W-2:0], 1'b0} ^ (fb ? CRC7_POLY : '0);
    end
endmodule

// File: rtl/cmd_deserializer.sv
// cmd_deserializer: armed serial-to-parallel receiver for the SD CMD line with end-bit, timeout
// and optional CRC7 checking (enabled by defining CMD_DESER_CRC7_EN).
import cmd_deser_pkg::*;
module cmd_deserializer #(
    parameter int   FRAME_W     = 48,
    parameter int   MSB_FIRST   = 1,
    parameter logic START_LVL   = 1'b0,
    parameter int   TIMEOUT_MAX = 64,
    parameter int   TO_W        = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               input_1,
    input  logic               arm,
    output logic [FRAME_W-1:0] output_n,
    output logic               push,
    output logic               frame_err,
    output logic               crc_err,
    output logic               timeout,
    output logic               busy
);
    localparam int CW = clog2(FRAME_W + 1);
    state_e             state_q;
    logic [CW-1:0]      bit_cnt_q;
    logic [TO_W-1:0]    to_cnt_q;
    logic [FRAME_W-1:0] sr_q, sr_d, out_q;
    logic               push_q, ferr_q, cerr_q, to_q;
    logic               last, arm_ok, crc_fail;
    assign sr_d     = (MSB_FIRST != 0) ? {sr_q[FRAME_W-2:0], input_1} : {input_1, sr_q[FRAME_W-1:1]};
    assign last     = bit_cnt_q == CW'(FRAME_W - 1);
    // push_q marks the cycle the frame is still being handed off, so a coincident arm is dropped
    assign arm_ok   = state_q == IDLE && arm && !push_q;
    assign output_n = out_q;
    assign push     = push_q;
    assign frame_err = ferr_q;
    assign crc_err  = cerr_q;
    assign timeout  = to_q;
    assign busy     = state_q != IDLE;
`ifdef CMD_DESER_CRC7_EN
    logic [CRC7_W-1:0] crc;
    logic              sample, crc_en, crc_chk, crc_bad_q;
    logic [2:0]        crc_sel;
    int                idx;
    always_comb begin
        idx     = (state_q == SHIFT) ? int'(bit_cnt_q) : 0;
        sample  = enable && (state_q == SHIFT || (state_q == WAIT_START && input_1 == START_LVL));
        crc_en  = sample && idx <= FRAME_W - 9;
        crc_chk = sample && idx >= FRAME_W - 8 && idx <= FRAME_W - 2;
        crc_sel = 3'(FRAME_W - 2 - idx);
    end
    crc7_serial u_crc (
        .clk    (clk),
        .reset  (reset),
        .clear  (arm_ok),
        .bit_en (crc_en),
        .bit_in (input_1),
        .crc    (crc)
    );
    // received CRC bits arrive MSB first and are compared one at a time as they stream in
    always_ff @(posedge clk) begin
        if (reset || arm_ok) crc_bad_q <= 1'b0;
        else if (crc_chk && input_1 != crc[crc_sel]) crc_bad_q <= 1'b1;
    end
    assign crc_fail = crc_bad_q;
`else
    assign crc_fail = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
            sr_q      <= '0;
            out_q     <= '0;
            push_q    <= 1'b0;
            ferr_q    <= 1'b0;
            cerr_q    <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            push_q <= 1'b0;
            ferr_q <= 1'b0;
            cerr_q <= 1'b0;
            to_q   <= 1'b0;
            case (state_q)
                IDLE: if (arm_ok) begin
                    state_q  <= WAIT_START;
                    to_cnt_q <= '0;
                end
                WAIT_START: if (enable) begin
                    if (input_1 == START_LVL) begin
                        sr_q      <= sr_d;
                        bit_cnt_q <= CW'(1);
                        state_q   <= SHIFT;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                        if (to_cnt_q == TO_W'(TIMEOUT_MAX - 1)) begin
                            to_q    <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                SHIFT: if (enable) begin
                    sr_q <= sr_d;
                    if (last) begin
                        out_q     <= sr_d;
                        push_q    <= 1'b1;
                        ferr_q    <= input_1 == START_LVL;
                        cerr_q    <= crc_fail;
                        bit_cnt_q <= '0;
                        state_q   <= IDLE;
                    end else bit_cnt_q <= bit_cnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cmd_deserializer.sv
// tb_cmd_deserializer: scoreboard bench for a 48-bit MSB-first and a 9-bit LSB-first deserializer.
module tb_cmd_deserializer;
`ifdef CMD_DESER_CRC7_EN
    localparam logic CRC_ON = 1'b1;
`else
    localparam logic CRC_ON = 1'b0;
`endif
    typedef struct packed {logic [47:0] data; logic ferr; logic cerr;} exp48_t;
    typedef struct packed {logic [8:0] data; logic ferr; logic cerr;} exp9_t;
    logic clk = 1'b0, reset = 1'b1;
    logic en, in1, arm, en9, in9, arm9;
    logic [47:0] out48;
    logic [8:0]  out9;
    logic push48, ferr48, cerr48, to48, busy48;
    logic push9, ferr9, cerr9, to9, busy9;
    exp48_t q48[$];
    exp9_t  q9[$];
    exp48_t e48;
    exp9_t  e9;
    int checks = 0, errors = 0, to_seen = 0;
    logic [8:0] b9 = 9'b110011010;

    always #5 clk = ~clk;

    cmd_deserializer u48 (
        .clk(clk), .reset(reset), .enable(en), .input_1(in1), .arm(arm),
        .output_n(out48), .push(push48), .frame_err(ferr48), .crc_err(cerr48),
        .timeout(to48), .busy(busy48)
    );
    cmd_deserializer #(.FRAME_W(9), .MSB_FIRST(0)) u9 (
        .clk(clk), .reset(reset), .enable(en9), .input_1(in9), .arm(arm9),
        .output_n(out9), .push(push9), .frame_err(ferr9), .crc_err(cerr9),
        .timeout(to9), .busy(busy9)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic b);
        in1 = b;
        en = 1'b1;
        tick();
        en = 1'b0;
        repeat (3) tick();
    endtask

    task automatic arm48();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic send(input logic [47:0] f, input int from, input int to);
        for (int i = from; i < to; i++) strobe(f[47-i]);
        in1 = 1'b1;
    endtask

    task automatic frame48(input logic [47:0] f, input logic ferr, input logic cerr);
        q48.push_back('{data: f, ferr: ferr, cerr: cerr});
        arm48();
        check("busy after arm", 64'(busy48), 64'd1);
        repeat (10) strobe(1'b1);
        send(f, 0, 48);
        repeat (4) tick();
        check("frame48 consumed", 64'(q48.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (push48) begin
            if (q48.size() == 0) check("push48 unexpected", 64'd1, 64'd0);
            else begin
                e48 = q48.pop_front();
                check("out48", 64'(out48), 64'(e48.data));
                check("ferr48", 64'(ferr48), 64'(e48.ferr));
                check("cerr48", 64'(cerr48), 64'(e48.cerr));
                check("busy48 on push", 64'(busy48), 64'd0);
            end
        end else if (ferr48 || cerr48) check("err48 without push", 64'({ferr48, cerr48}), 64'd0);
        if (push9) begin
            if (q9.size() == 0) check("push9 unexpected", 64'd1, 64'd0);
            else begin
                e9 = q9.pop_front();
                check("out9", 64'(out9), 64'(e9.data));
                check("ferr9", 64'(ferr9), 64'(e9.ferr));
                check("cerr9", 64'(cerr9), 64'(e9.cerr));
            end
        end else if (ferr9 || cerr9) check("err9 without push", 64'({ferr9, cerr9}), 64'd0);
        if (to48) to_seen++;
        if (to9) check("timeout9 unexpected", 64'd1, 64'd0);
    end

    initial begin
        en = 1'b0; in1 = 1'b1; arm = 1'b0;
        en9 = 1'b0; in9 = 1'b1; arm9 = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset output_n", 64'(out48), 64'd0);
        check("reset flags", 64'({push48, ferr48, cerr48, to48, busy48}), 64'd0);
        check("reset busy9", 64'(busy9), 64'd0);
        // good frame, bad end bit, bad CRC field
        frame48(48'h400000000095, 1'b0, 1'b0);
        frame48(48'h400000000094, 1'b1, 1'b0);
        frame48(48'h4000000000FF, 1'b0, CRC_ON);
        // response timeout
        arm48();
        for (int i = 0; i < 63; i++) strobe(1'b1);
        check("no timeout before 64", 64'(to_seen), 64'd0);
        check("busy before timeout", 64'(busy48), 64'd1);
        in1 = 1'b1;
        en = 1'b1;
        tick();
        en = 1'b0;
        check("timeout pulse", 64'(to48), 64'd1);
        check("busy falls with timeout", 64'(busy48), 64'd0);
        repeat (5) tick();
        check("timeout once", 64'(to_seen), 64'd1);
        // reset mid-frame, then a full frame after re-arm
        arm48();
        repeat (3) strobe(1'b1);
        send(48'h400000000095, 0, 20);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("output_n after reset", 64'(out48), 64'd0);
        check("busy after reset", 64'(busy48), 64'd0);
        tick();
        q48.push_back('{data: 48'h400000000095, ferr: 1'b0, cerr: 1'b0});
        arm48();
        send(48'h400000000095, 0, 47);
        check("output_n held at 0", 64'(out48), 64'd0);
        send(48'h400000000095, 47, 48);
        repeat (4) tick();
        check("frame after reset consumed", 64'(q48.size()), 64'd0);
        // 9-bit LSB-first frame with stray arms mid-frame and in the push cycle
        q9.push_back('{data: 9'b110011010, ferr: 1'b0, cerr: CRC_ON});
        arm9 = 1'b1;
        tick();
        arm9 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in9 = b9[i];
            en9 = 1'b1;
            tick();
            en9 = 1'b0;
            if (i == 4 || i == 8) begin
                if (i == 8) check("push9 at final bit", 64'(push9), 64'd1);
                arm9 = 1'b1;
                tick();
                arm9 = 1'b0;
                repeat (2) tick();
            end else repeat (3) tick();
        end
        in9 = 1'b1;
        check("busy9 after push", 64'(busy9), 64'd0);
        repeat (4) tick();
        check("busy9 stays low", 64'(busy9), 64'd0);
        check("frame9 consumed", 64'(q9.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
